// File: rtl/rgb_fade_pkg.sv
// Shared types and ramp arithmetic for the RGB hue-wheel fade sequencer.
package rgb_fade_pkg;

  localparam int unsigned RAMP_W = 32;

  typedef enum logic {IDLE, RUN} fade_state_t;

  typedef enum logic [2:0] {
    SECT_0 = 3'd0,
    SECT_1 = 3'd1,
    SECT_2 = 3'd2,
    SECT_3 = 3'd3,
    SECT_4 = 3'd4,
    SECT_5 = 3'd5
  } sector_t;

  // One clamped ramp step: saturates at full going up and at zero going down.
  function automatic logic [RAMP_W-1:0] ramp_step(
    input logic [RAMP_W-1:0] value,
    input logic              up,
    input logic [RAMP_W-1:0] step,
    input logic [RAMP_W-1:0] full
  );
    logic [RAMP_W:0] sum;
    sum = {1'b0, value} + {1'b0, step};
    if (up) begin
      ramp_step = (sum > {1'b0, full}) ? full : sum[RAMP_W-1:0];
    end else begin
      ramp_step = (value < step) ? '0 : value - step;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running cycle prescaler producing a strobe every CYCLES unheld cycles.
module tick_prescaler #(
  parameter int unsigned CYCLES = 12000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned   CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign tick   = w_last & ~hold & ~clr;

  // Count 0..CYCLES-1 and wrap; clear restarts from zero, hold freezes.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (!hold) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Six-sector HSV hue sweep driving the red/green/blue PWM duty inputs.
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP_CYCLES  = 12000,
  parameter int unsigned DUTY_STEP    = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            pause,
  output logic [$clog2(PWM_INTERVAL)-1:0] red_pwm_value,
  output logic [$clog2(PWM_INTERVAL)-1:0] green_pwm_value,
  output logic [$clog2(PWM_INTERVAL)-1:0] blue_pwm_value,
  output logic [2:0]                      sector,
  output logic                            step_tick,
  output logic                            running
);

  localparam int unsigned  W    = $clog2(PWM_INTERVAL);
  localparam logic [W-1:0] FULL = W'(PWM_INTERVAL);

  if ((PWM_INTERVAL < 2) || ((PWM_INTERVAL & (PWM_INTERVAL - 1)) == 0)) begin : g_bad_interval
    $error("PWM_INTERVAL must be >= 2 and not a power of two");
  end
  if (STEP_CYCLES < 1) begin : g_bad_cycles
    $error("STEP_CYCLES must be >= 1");
  end
  if ((DUTY_STEP < 1) || (DUTY_STEP > PWM_INTERVAL)) begin : g_bad_step
    $error("DUTY_STEP must be in 1..PWM_INTERVAL");
  end

  fade_state_t  r_state, w_state_nxt;
  sector_t      r_sector, w_sector_nxt, w_sector_inc;
  logic [W-1:0] r_red, r_green, r_blue;
  logic [W-1:0] w_red_nxt, w_green_nxt, w_blue_nxt;
  logic         r_step_tick, w_step_tick_nxt;
  logic [W-1:0] w_ramp_cur, w_ramp_target, w_ramp_next;
  logic         w_ramp_up, w_at_target;
  logic         w_clr, w_hold, w_tick;

  // Prescaler runs only in RUN with enable held; pause freezes it.
  assign w_clr  = (r_state != RUN) | ~enable;
  assign w_hold = pause;

  tick_prescaler #(
    .CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .hold (w_hold),
    .tick (w_tick)
  );

  // Sector table: pick the ramping channel, its direction and its target.
  always_comb begin
    w_ramp_cur = r_green;
    w_ramp_up  = 1'b1;
    case (r_sector)
      SECT_0: begin w_ramp_cur = r_green; w_ramp_up = 1'b1; end
      SECT_1: begin w_ramp_cur = r_red;   w_ramp_up = 1'b0; end
      SECT_2: begin w_ramp_cur = r_blue;  w_ramp_up = 1'b1; end
      SECT_3: begin w_ramp_cur = r_green; w_ramp_up = 1'b0; end
      SECT_4: begin w_ramp_cur = r_red;   w_ramp_up = 1'b1; end
      SECT_5: begin w_ramp_cur = r_blue;  w_ramp_up = 1'b0; end
      default: ;
    endcase
    w_ramp_target = w_ramp_up ? FULL : '0;
    w_at_target   = (w_ramp_cur == w_ramp_target);
    w_ramp_next   = W'(ramp_step(RAMP_W'(w_ramp_cur), w_ramp_up,
                                 RAMP_W'(DUTY_STEP), RAMP_W'(PWM_INTERVAL)));
    w_sector_inc  = (r_sector == SECT_5) ? SECT_0 : sector_t'(r_sector + 3'd1);
  end

  // Next-state and next-output logic; enable drop beats a coincident tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_sector_nxt    = r_sector;
    w_red_nxt       = r_red;
    w_green_nxt     = r_green;
    w_blue_nxt      = r_blue;
    w_step_tick_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_sector_nxt = SECT_0;
        w_red_nxt    = '0;
        w_green_nxt  = '0;
        w_blue_nxt   = '0;
        if (enable) begin
          w_state_nxt = RUN;
          w_red_nxt   = FULL;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt  = IDLE;
          w_sector_nxt = SECT_0;
          w_red_nxt    = '0;
          w_green_nxt  = '0;
          w_blue_nxt   = '0;
        end else if (w_tick) begin
          w_step_tick_nxt = 1'b1;
          if (w_at_target) begin
            w_sector_nxt = w_sector_inc;
          end else begin
            case (r_sector)
              SECT_1, SECT_4: w_red_nxt   = w_ramp_next;
              SECT_0, SECT_3: w_green_nxt = w_ramp_next;
              SECT_2, SECT_5: w_blue_nxt  = w_ramp_next;
              default: ;
            endcase
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sector    <= SECT_0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_step_tick <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sector    <= w_sector_nxt;
      r_red       <= w_red_nxt;
      r_green     <= w_green_nxt;
      r_blue      <= w_blue_nxt;
      r_step_tick <= w_step_tick_nxt;
    end
  end

  assign red_pwm_value   = r_red;
  assign green_pwm_value = r_green;
  assign blue_pwm_value  = r_blue;
  assign sector          = r_sector;
  assign step_tick       = r_step_tick;
  assign running         = (r_state == RUN);

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Controller that drives the three duty-cycle inputs of the RGB PWM generator so the LED sweeps continuously around the hue wheel.
Runs a 6-sector HSV sequence. In each sector one channel is held full, one is held off, and one ramps linearly.
Ramp speed is set by a clock prescaler and a duty step size. Supports enable (run/off) and pause (freeze).
Sits between top-level control inputs and the PWM generator, one instance per RGB LED.

Parameters:
PWM_INTERVAL, 1200, PWM period in clk cycles. Full-on duty value is PWM_INTERVAL. Must not be a power of two, so PWM_INTERVAL fits in W = $clog2(PWM_INTERVAL) bits; elaboration assertion.
STEP_CYCLES, 12000, clk cycles between ramp ticks (1 ms at 12 MHz). Must be ≥ 1.
DUTY_STEP, 12, duty increment or decrement applied per tick. Must satisfy 1 ≤ DUTY_STEP ≤ PWM_INTERVAL.

Ports:
clk  in  1  system clock, 12 MHz
reset  in  1  synchronous reset, active-high
enable  in  1  level; high = run sequence, low = LED off
pause  in  1  level; high while running = freeze prescaler and duty values
red_pwm_value  out  W  duty to PWM red input
green_pwm_value  out  W  duty to PWM green input
blue_pwm_value  out  W  duty to PWM blue input
sector  out  3  current hue sector, 0..5
step_tick  out  1  one-cycle strobe when a ramp tick is applied
running  out  1  high in RUN state

Behaviour:
- Reset is synchronous, active-high, on posedge clk, and has priority over everything. After reset:
  - state IDLE, sector 0, prescaler 0
  - all duty outputs 0, step_tick 0, running 0
- IDLE state:
  - duty outputs forced 0
  - enable=1 at edge n -> at edge n+1: state RUN, sector 0, R=PWM_INTERVAL, G=0, B=0, prescaler 0, running=1.
- RUN state, enable=0: next edge returns to IDLE, duties 0, sector 0. This also applies mid-ramp; there is no resume point.
- RUN state, pause=1 (and enable=1):
  - prescaler and duties held, step_tick 0
  - releasing pause continues the count from the held prescaler value
- RUN state, pause=0: prescaler counts 0..STEP_CYCLES-1 and wraps. The tick is the cycle where the prescaler equals STEP_CYCLES-1.
  - First tick occurs STEP_CYCLES cycles after entering RUN.
- Sector table (held-full / held-off / ramping channel and direction):
  - 0: R full, B off, G up to FULL
  - 1: G full, B off, R down to 0
  - 2: G full, R off, B up to FULL
  - 3: B full, R off, G down to 0
  - 4: B full, G off, R up to FULL
  - 5: R full, G off, B down to 0
  - after 5: wrap to 0
- On each tick, exactly one action happens:
  - If the ramping channel already equals its target: sector advances (5 wraps to 0) and duties are unchanged this tick.
  - Otherwise, ramp up: v <= min(v+DUTY_STEP, PWM_INTERVAL), computed in W+1 bits to avoid overflow.
  - Otherwise, ramp down: v <= (v < DUTY_STEP) ? 0 : v-DUTY_STEP. No underflow.
- The new sector's ramping channel already sits at its starting value, so transitions are seamless.
- Ticks per sector: ceil(PWM_INTERVAL/DUTY_STEP)+1.
- step_tick is registered and asserts in the same cycle the duty/sector update becomes visible.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Simultaneous enable fall and tick: enable wins, so the next state is IDLE and the tick is dropped.

Decomposition:
- Package rgb_fade_pkg holds:
  - typedef enum logic {IDLE, RUN} fade_state_t
  - typedef enum logic [2:0] sector_t, values SECT_0..SECT_5
  - function ramp_step(value, up, step, full) returning the clamped next value
- One sub-module, tick_prescaler (params CYCLES; ports clk, reset, clr, hold, tick). It is reusable for other timed sequencers.
- Sector table and state machine stay in rgb_fade_sequencer.

Test Plan:
All scenarios use PWM_INTERVAL=10, STEP_CYCLES=4, DUTY_STEP=3.
1. Reset held, then enable=1 for one cycle -> next edge running=1, sector=0, R=10, G=0, B=0. First step_tick 4 cycles later with G=3.
2. Run sector 0 -> G sequence 0,3,6,9,10 on ticks 1-4. Tick 5: sector=1 with duties unchanged. Then R goes 10,7,4,1,0.
3. Run 30 ticks (120 cycles) from entry -> sector back to 0 and R=10, G=0, B=0. Checks the wrap.
4. pause=1 for 7 cycles mid-ramp -> duties, sector and step_tick frozen. The next tick lands exactly 7 cycles later than without pause.
5. enable=0 mid-sector 3 -> next edge IDLE, all duties 0, sector=0. Re-enable -> restarts at R=10, G=0, B=0.
6. reset=1 during a tick cycle in RUN -> next edge all outputs 0, IDLE, no step_tick. Also: enable drop coincident with a tick -> IDLE, step_tick=0.
